// File: rtl/bypass_wire_fifo2_pkg.sv
// Shared definitions for the two-entry bypass FIFO: occupancy encoding,
// store control bundle and the occupancy update rule.
package bypass_fifo_pkg;

  localparam int COUNT_W = 2;

  localparam logic [COUNT_W-1:0] CNT_EMPTY = 2'd0;
  localparam logic [COUNT_W-1:0] CNT_ONE   = 2'd1;
  localparam logic [COUNT_W-1:0] CNT_FULL  = 2'd2;

  // Load/shift commands from the control decode to the data store.
  typedef struct packed {
    logic load_h0;  // h0 <= D_IN
    logic load_h1;  // h1 <= D_IN
    logic shift;    // h0 <= h1
  } store_ctl_t;

  // Occupancy after one edge. enq_ok/deq_ok are the already-legalised
  // strobes; a bypass (enq_ok & deq_ok at empty) leaves the count alone.
  function automatic logic [COUNT_W-1:0] next_count(
    input logic [COUNT_W-1:0] cnt,
    input logic               enq_ok,
    input logic               deq_ok,
    input logic               clr
  );
    logic [COUNT_W-1:0] nxt;
    nxt = cnt;
    if (clr) begin
      nxt = CNT_EMPTY;
    end else if (enq_ok && !deq_ok) begin
      nxt = cnt + 2'd1;
    end else if (!enq_ok && deq_ok) begin
      nxt = cnt - 2'd1;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bypass_wire_fifo2_if.sv
// Producer/consumer handshake bundle of the bypass FIFO.
// master = the side driving data and strobes, slave = the FIFO.
interface bypass_wire_fifo2_if #(
  parameter int width = 1
);

  logic [width-1:0] D_IN;
  logic             ENQ;
  logic             FULL_N;
  logic [width-1:0] D_OUT;
  logic             EMPTY_N;
  logic             DEQ;
  logic             CLR;
  logic             ERR;

  modport master (
    output D_IN, ENQ, DEQ, CLR,
    input  FULL_N, D_OUT, EMPTY_N, ERR
  );

  modport slave (
    input  D_IN, ENQ, DEQ, CLR,
    output FULL_N, D_OUT, EMPTY_N, ERR
  );

endinterface

// File: rtl/bypass_wire_fifo2_store.sv
// Data storage of the bypass FIFO: head h0 and tail h1. No reset on the
// data path; validity is tracked entirely by the count in the top level.
module bypass_fifo2_store
  import bypass_fifo_pkg::*;
#(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic [width-1:0] din,
  input  store_ctl_t       ctl,
  output logic [width-1:0] h0,
  output logic [width-1:0] h1
);

  // Head register: loaded from D_IN, or advanced from the tail on a dequeue at full.
  always_ff @(posedge clk) begin
    if (ctl.load_h0) begin
      h0 <= din;
    end else if (ctl.shift) begin
      h0 <= h1;
    end else begin
      h0 <= h0;
    end
  end

  // Tail register: only ever written by an enqueue into a one-entry FIFO.
  always_ff @(posedge clk) begin
    if (ctl.load_h1) begin
      h1 <= din;
    end else begin
      h1 <= h1;
    end
  end

endmodule

// File: rtl/bypass_wire_fifo2.sv
// Two-entry bypass FIFO. With nothing buffered, an enqueued beat is
// forwarded combinationally to D_OUT; a stalled consumer gets up to two
// beats of buffering. Count, control decode and the sticky ERR live here.
module bypass_wire_fifo2
  import bypass_fifo_pkg::*;
#(
  parameter int width   = 1,
  parameter int guarded = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  bypass_wire_fifo2_if.slave  bus
);

  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_nxt;
  logic               has_data;
  logic               full_n;
  logic               enq_ok;
  logic               deq_ok;
  logic               empty_n;
  logic               ill_enq;
  logic               ill_deq;
  logic               err;
  logic               err_set;
  store_ctl_t         ctl;
  logic [width-1:0]   h0;
  logic [width-1:0]   h1;

  // Handshake decode: legalise the strobes against the registered count.
  always_comb begin
    has_data = (count != CNT_EMPTY);
    full_n   = (count != CNT_FULL);
    enq_ok   = bus.ENQ & full_n;
    empty_n  = has_data | enq_ok;
    deq_ok   = bus.DEQ & empty_n;
    // A flush overrides the strobes, so they cannot be protocol errors then.
    ill_enq  = bus.ENQ & ~full_n & ~bus.CLR;
    ill_deq  = bus.DEQ & ~empty_n & ~bus.CLR;
    if (guarded != 0) begin
      err_set = ill_enq | ill_deq;
    end else begin
      err_set = 1'b0;
    end
    count_nxt = next_count(count, enq_ok, deq_ok, bus.CLR);
  end

  // Store command decode: where incoming data lands, and when the tail moves up.
  always_comb begin
    ctl = '0;
    if (bus.CLR) begin
      ctl = '0;
    end else begin
      case (count)
        CNT_EMPTY: begin
          // Enqueue without dequeue parks the beat; with dequeue it bypasses.
          ctl.load_h0 = enq_ok & ~deq_ok;
        end
        CNT_ONE: begin
          // Simultaneous enq/deq replaces the head; enq alone fills the tail.
          ctl.load_h0 = enq_ok & deq_ok;
          ctl.load_h1 = enq_ok & ~deq_ok;
        end
        CNT_FULL: begin
          ctl.shift = deq_ok;
        end
        default: begin
          ctl = '0;
        end
      endcase
    end
  end

  // Occupancy register; reset empties the FIFO immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= CNT_EMPTY;
    end else begin
      count <= count_nxt;
    end
  end

  // Sticky protocol-violation flag; only reset clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err <= 1'b0;
    end else begin
      err <= err | err_set;
    end
  end

  bypass_fifo2_store #(
    .width (width)
  ) u_store (
    .clk (CLK),
    .din (bus.D_IN),
    .ctl (ctl),
    .h0  (h0),
    .h1  (h1)
  );

  assign bus.FULL_N  = full_n;
  assign bus.EMPTY_N = empty_n;
  assign bus.D_OUT   = has_data ? h0 : bus.D_IN;
  assign bus.ERR     = err;

endmodule

// File: tb/tb_bypass_wire_fifo2.sv
// Self-checking bench for bypass_wire_fifo2: a guarded and an unguarded
// instance share identical stimulus; a queue scoreboard tracks contents.
module tb_bypass_wire_fifo2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bypass_wire_fifo2_if #(.width(8)) bus0 ();
  bypass_wire_fifo2_if #(.width(8)) bus1 ();

  bypass_wire_fifo2 #(.width(8), .guarded(1)) dut0 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus0)
  );

  bypass_wire_fifo2 #(.width(8), .guarded(0)) dut1 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    logic       enq;
    logic       deq;
    logic       clr;
    logic [7:0] din;
    logic       en;
    logic       fn;
    logic [7:0] dout;
    logic       err;
  } vec_t;

  vec_t       tbl [22];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] q [$];
  logic       err_exp = 1'b0;
  logic       s_en;
  logic       s_fn;
  logic       s_err;
  logic [7:0] s_dout;

  function automatic vec_t mk(input logic enq, input logic deq, input logic clr,
                              input logic [7:0] din, input logic en, input logic fn,
                              input logic [7:0] dout, input logic err);
    vec_t v;
    v.enq = enq; v.deq = deq; v.clr = clr; v.din = din;
    v.en = en; v.fn = fn; v.dout = dout; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic enq, input logic deq, input logic clr, input logic [7:0] din);
    bus0.ENQ = enq; bus0.DEQ = deq; bus0.CLR = clr; bus0.D_IN = din;
    bus1.ENQ = enq; bus1.DEQ = deq; bus1.CLR = clr; bus1.D_IN = din;
  endtask

  // One clock cycle: drive after the falling edge, sample mid-cycle, update the scoreboard at the rising edge.
  task automatic cycle(input logic enq, input logic deq, input logic clr, input logic [7:0] din);
    logic exp_fn, legal_enq, exp_en, legal_deq;
    @(negedge clk);
    set_in(enq, deq, clr, din);
    #2;
    s_en   = bus0.EMPTY_N;
    s_fn   = bus0.FULL_N;
    s_err  = bus0.ERR;
    s_dout = bus0.D_OUT;
    exp_fn    = (q.size() < 2);
    legal_enq = enq && exp_fn;
    exp_en    = (q.size() != 0) || legal_enq;
    legal_deq = deq && exp_en;
    chk("sb_full_n", s_fn, exp_fn);
    chk("sb_empty_n", s_en, exp_en);
    chk("sb_err", s_err, err_exp);
    chk("err_unguarded", bus1.ERR, 1'b0);
    if (legal_enq) q.push_back(din);
    if (legal_deq) begin
      chk("sb_dout", s_dout, q[0]);
      void'(q.pop_front());
    end
    @(posedge clk);
    if (clr) begin
      q.delete();
    end else begin
      if (enq && !legal_enq) err_exp = 1'b1;
      if (deq && !legal_deq) err_exp = 1'b1;
    end
  endtask

  // Async reset pulse between edges; contents must vanish before the next edge.
  task automatic reset_pulse();
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    err_exp = 1'b0;
    chk("rst_full_n", bus0.FULL_N, 1'b1);
    chk("rst_empty_n", bus0.EMPTY_N, 1'b0);
    chk("rst_err", bus0.ERR, 1'b0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // bypass at empty, then idle
    tbl[0]  = mk(1, 1, 0, 8'hA5, 1, 1, 8'hA5, 0);
    tbl[1]  = mk(0, 0, 0, 8'h00, 0, 1, 8'h00, 0);
    // fill two, drain two
    tbl[2]  = mk(1, 0, 0, 8'h11, 1, 1, 8'h11, 0);
    tbl[3]  = mk(1, 0, 0, 8'h22, 1, 1, 8'h11, 0);
    tbl[4]  = mk(0, 0, 0, 8'h00, 1, 0, 8'h11, 0);
    tbl[5]  = mk(0, 1, 0, 8'h00, 1, 0, 8'h11, 0);
    tbl[6]  = mk(0, 1, 0, 8'h00, 1, 1, 8'h22, 0);
    tbl[7]  = mk(0, 0, 0, 8'h00, 0, 1, 8'h00, 0);
    // overflow while full: 0x33 dropped, ERR sticks
    tbl[8]  = mk(1, 0, 0, 8'h11, 1, 1, 8'h11, 0);
    tbl[9]  = mk(1, 0, 0, 8'h22, 1, 1, 8'h11, 0);
    tbl[10] = mk(1, 0, 0, 8'h33, 1, 0, 8'h11, 0);
    tbl[11] = mk(0, 0, 0, 8'h00, 1, 0, 8'h11, 1);
    tbl[12] = mk(0, 1, 0, 8'h00, 1, 0, 8'h11, 1);
    tbl[13] = mk(0, 1, 0, 8'h00, 1, 1, 8'h22, 1);
    tbl[14] = mk(0, 0, 0, 8'h00, 0, 1, 8'h00, 1);
    // flush a full FIFO together with ENQ
    tbl[15] = mk(1, 0, 0, 8'h66, 1, 1, 8'h66, 1);
    tbl[16] = mk(1, 0, 0, 8'h77, 1, 1, 8'h66, 1);
    tbl[17] = mk(1, 0, 1, 8'h88, 1, 0, 8'h66, 1);
    tbl[18] = mk(0, 0, 0, 8'h00, 0, 1, 8'h00, 1);
    // bypass still visible during a flush
    tbl[19] = mk(1, 1, 1, 8'h99, 1, 1, 8'h99, 1);
    tbl[20] = mk(0, 0, 0, 8'h00, 0, 1, 8'h00, 1);
    // leave one beat (0x44) for the streaming run
    tbl[21] = mk(1, 0, 0, 8'h44, 1, 1, 8'h44, 1);

    // reset state, and EMPTY_N following ENQ while in reset
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    #12;
    chk("reset_full_n", bus0.FULL_N, 1'b1);
    chk("reset_empty_n", bus0.EMPTY_N, 1'b0);
    chk("reset_err", bus0.ERR, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 8'h5A);
    #1;
    chk("reset_enq_empty_n", bus0.EMPTY_N, 1'b1);
    chk("reset_enq_dout", bus0.D_OUT, 8'h5A);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("reset_held_empty_n", bus0.EMPTY_N, 1'b0);
    chk("reset_held_full_n", bus0.FULL_N, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].enq, tbl[i].deq, tbl[i].clr, tbl[i].din);
      chk($sformatf("vec%0d_empty_n", i), s_en, tbl[i].en);
      chk($sformatf("vec%0d_full_n", i), s_fn, tbl[i].fn);
      chk($sformatf("vec%0d_err", i), s_err, tbl[i].err);
      if (tbl[i].en) chk($sformatf("vec%0d_dout", i), s_dout, tbl[i].dout);
    end

    // sustained simultaneous enq/deq at count=1: no stall, in-order output
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h55 + 8'(i));
      chk("stream_full_n", s_fn, 1'b1);
      chk("stream_dout", s_dout, (i == 0) ? 8'h44 : 8'h55 + 8'(i - 1));
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("stream_last", s_dout, 8'h5C);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("stream_drained", s_en, 1'b0);

    // mid-operation reset on a full FIFO with ERR set
    cycle(1'b1, 1'b0, 1'b0, 8'hAA);
    cycle(1'b1, 1'b0, 1'b0, 8'hBB);
    cycle(1'b0, 0, 1'b0, 8'h00);
    chk("pre_rst_full_n", s_fn, 1'b0);
    reset_pulse();

    // repeat overflow: guarded instance flags it, unguarded does not
    cycle(1'b1, 1'b0, 1'b0, 8'h11);
    cycle(1'b1, 1'b0, 1'b0, 8'h22);
    cycle(1'b1, 1'b0, 1'b0, 8'h33);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf2_err_guarded", s_err, 1'b1);
    chk("ovf2_err_unguarded", bus1.ERR, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ovf2_dout0", s_dout, 8'h11);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ovf2_dout1", s_dout, 8'h22);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf2_empty", s_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bypass_wire_fifo2.md
Name: bypass_wire_fifo2

Overview:
- Two-entry, single-clock bypass FIFO. It is the registered receiving end for a crossing/bypass wire: the producer drives data plus an enqueue strobe, and the consumer reads data with a valid flag and a dequeue strobe.
- When the FIFO is empty, enqueued data is visible on D_OUT in the same cycle (zero-latency bypass). When the consumer stalls, up to two beats are buffered.
- Used inside BSV-generated primitives wherever a wire's producer cannot be back-pressured combinationally.

Parameters:
- width, 1: data width in bits.
- guarded, 1: 1 = set ERR on illegal ENQ/DEQ; 0 = ERR held at 0.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- D_IN  input  width  enqueue data.
- ENQ  input  1  enqueue strobe; legal only when FULL_N=1.
- FULL_N  output  1  1 = at least one free slot (registered).
- D_OUT  output  width  head data; valid only when EMPTY_N=1.
- EMPTY_N  output  1  1 = D_OUT valid (combinational, includes bypass).
- DEQ  input  1  dequeue strobe; legal only when EMPTY_N=1.
- CLR  input  1  synchronous flush.
- ERR  output  1  sticky protocol-violation flag.

Behaviour:
- State: count (0..2), head register h0, tail register h1. Data registers are not reset.
- Reset (RST_N=0, asynchronous): count=0, FULL_N=1, ERR=0. EMPTY_N follows ENQ while in reset, but ENQ/DEQ have no effect on state.
- EMPTY_N = (count!=0) | (ENQ & FULL_N).
- D_OUT = (count!=0) ? h0 : D_IN.
- FULL_N = (count!=2), derived from the registered count; no combinational path from DEQ.
- count=0:
  - ENQ & DEQ: bypass; count stays 0.
  - ENQ only: h0<=D_IN, count=1.
  - DEQ only: illegal.
- count=1:
  - ENQ & DEQ: h0<=D_IN, count stays 1.
  - ENQ only: h1<=D_IN, count=2.
  - DEQ only: count=0.
- count=2:
  - DEQ: h0<=h1, count=1. ENQ is illegal in the same cycle (FULL_N=0); the DEQ still executes.
- Illegal ENQ (FULL_N=0): data is dropped and state is unchanged by the ENQ. If guarded=1, ERR<=1.
- Illegal DEQ (EMPTY_N=0): ignored. If guarded=1, ERR<=1.
- CLR=1: count<=0 next cycle, overriding ENQ/DEQ in that cycle.
  - A bypass transfer in the CLR cycle is still visible combinationally on D_OUT.
  - ERR is not cleared by CLR; only reset clears ERR.
- Reset asserted mid-operation: contents are discarded immediately and FULL_N=1 asynchronously.
- Throughput: 1 beat/cycle sustained with simultaneous ENQ/DEQ at any count<2.

Decomposition:
- Shared package bypass_fifo_pkg:
  - COUNT_W=2.
  - Constants CNT_EMPTY=0, CNT_ONE=1, CNT_FULL=2.
  - Next-count function.
- Natural sub-module: bypass_fifo2_store. It holds h0/h1 and performs the load/shift muxing driven by the control decode. Control, count and ERR live in the top module.

Test Plan:
- Reset, then count=0, ENQ=1, DEQ=1, D_IN=0xA5 in the same cycle -> EMPTY_N=1, D_OUT=0xA5 that cycle; next cycle EMPTY_N=0, FULL_N=1.
- ENQ 0x11, then 0x22 with DEQ=0 -> FULL_N=0 after the second edge. DEQ twice -> D_OUT=0x11, then 0x22, then EMPTY_N=0, FULL_N=1.
- Full with 0x11/0x22, then ENQ=1, D_IN=0x33 -> 0x33 dropped, ERR=1 and stays 1. Subsequent DEQs return 0x11, 0x22 only.
- count=1 holding 0x44, ENQ 0x55 with DEQ each cycle for 8 cycles of incrementing data -> no stall, ordered output, count remains 1, FULL_N=1 throughout.
- Full FIFO, CLR=1 together with ENQ=1 -> next cycle count=0, EMPTY_N=0, FULL_N=1, ERR unchanged.
- Full FIFO, RST_N pulsed low between clock edges -> FULL_N=1 and EMPTY_N=0 before the next edge; ERR=0. With guarded=0, repeat the overflow scenario -> ERR stays 0.
